up_sample_nn_op_ctrl: RTL and testbench

Loop-nest controller and single-stage datapath for op_hcompute_nearest_neighbor_stencil in the up_sample app.
- Sweeps the 128x128 output iteration domain after a start pulse.
- Drives the read port of hw_input_stencil_ub (ren plus ctrl_vars) and captures the combinational read data.
- Issues the matching write, one cycle later, to the write port of nearest_neighbor_stencil_ub.
- Sits between the two unified buffers. The input buffer applies the floor(/2) address mapping itself, so this block emits full-resolution coordinates only.

---
 rtl/up_sample_nn_op_ctrl.sv | 169 ++++++++++++++++
 tb/tb_up_sample_nn_op_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/up_sample_nn_op_ctrl.sv
// Loop-nest controller for op_hcompute_nearest_neighbor_stencil: sweeps the
// full-resolution output domain, reads hw_input_stencil_ub and writes nearest_neighbor_stencil_ub.
module up_sample_nn_op_ctrl #(
    parameter int unsigned EXTENT_X    = 128,
    parameter int unsigned EXTENT_Y    = 128,
    parameter int unsigned START_DELAY = 4096,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic              stall,
    output logic              in_ren,
    output logic [15:0]       in_ctrl_vars  [2:0],
    input  logic [DATA_W-1:0] in_data       [0:0],
    output logic              out_wen,
    output logic [15:0]       out_ctrl_vars [2:0],
    output logic [DATA_W-1:0] out_data      [0:0],
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [15:0] X_LAST   = 16'(EXTENT_X - 1);
    localparam logic [15:0] Y_LAST   = 16'(EXTENT_Y - 1);
    localparam logic [31:0] DLY_LOAD = (START_DELAY == 0) ? 32'd0 : 32'(START_DELAY - 1);

    state_t            state_r, state_next_s;
    logic [15:0]       x_r, y_r, x_next_s, y_next_s;
    logic [31:0]       dly_r, dly_next_s;
    logic              ren_s;
    logic              out_wen_r;
    logic [15:0]       out_ctrl_r [2:0];
    logic [DATA_W-1:0] out_data_r;
    logic              busy_r;
    logic              done_r;

    // Next-state, counter and read-enable logic
    always_comb begin
        state_next_s = state_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        dly_next_s   = dly_r;
        ren_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    x_next_s = 16'd0;
                    y_next_s = 16'd0;
                    if (START_DELAY == 0) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_WAIT;
                        dly_next_s   = DLY_LOAD;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (dly_r == 32'd0) begin
                    state_next_s = ST_RUN;
                    x_next_s     = 16'd0;
                    y_next_s     = 16'd0;
                end else begin
                    dly_next_s = dly_r - 32'd1;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    ren_s = 1'b1;
                    if (x_r == X_LAST) begin
                        x_next_s = 16'd0;
                        if (y_r == Y_LAST) begin
                            // Counters return to zero so the block idles at the origin
                            y_next_s     = 16'd0;
                            state_next_s = ST_DRAIN;
                        end else begin
                            y_next_s = y_r + 16'd1;
                        end
                    end else begin
                        x_next_s = x_r + 16'd1;
                    end
                end else begin
                    ren_s = 1'b0;
                end
            end
            ST_DRAIN: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counters and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            x_r     <= 16'd0;
            y_r     <= 16'd0;
            dly_r   <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else if (flush) begin
            state_r <= ST_IDLE;
            x_r     <= 16'd0;
            y_r     <= 16'd0;
            dly_r   <= 32'd0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            x_r     <= x_next_s;
            y_r     <= y_next_s;
            dly_r   <= dly_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
            done_r  <= (state_next_s == ST_DRAIN);
        end
    end

    // Single write stage: the read issued this cycle becomes next cycle's write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_wen_r     <= 1'b0;
            out_ctrl_r[0] <= 16'd0;
            out_ctrl_r[1] <= 16'd0;
            out_ctrl_r[2] <= 16'd0;
            out_data_r    <= '0;
        end else if (flush) begin
            out_wen_r     <= 1'b0;
            out_ctrl_r[0] <= 16'd0;
            out_ctrl_r[1] <= 16'd0;
            out_ctrl_r[2] <= 16'd0;
            out_data_r    <= '0;
        end else begin
            out_wen_r     <= ren_s;
            out_ctrl_r[0] <= 16'd0;
            out_ctrl_r[1] <= y_r;
            out_ctrl_r[2] <= x_r;
            if (ren_s) begin
                out_data_r <= in_data[0];
            end else begin
                out_data_r <= out_data_r;
            end
        end
    end

    assign in_ren           = ren_s;
    assign in_ctrl_vars[0]  = 16'd0;
    assign in_ctrl_vars[1]  = y_r;
    assign in_ctrl_vars[2]  = x_r;
    assign out_wen          = out_wen_r;
    assign out_ctrl_vars[0] = out_ctrl_r[0];
    assign out_ctrl_vars[1] = out_ctrl_r[1];
    assign out_ctrl_vars[2] = out_ctrl_r[2];
    assign out_data[0]      = out_data_r;
    assign busy             = busy_r;
    assign done             = done_r;

endmodule

// File: tb/tb_up_sample_nn_op_ctrl.sv
// Bench for up_sample_nn_op_ctrl: a small-extent instance checked against a
// cycle table, and a full-size instance checked against a sweep-position model.
module tb_up_sample_nn_op_ctrl;

    localparam int EXA = 128;
    localparam int EYA = 128;
    localparam int DA  = 4;
    localparam int NA  = EXA * EYA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        a_flush, a_start, a_stall, a_in_ren, a_out_wen, a_busy, a_done;
    logic [15:0] a_in_ctrl [2:0];
    logic [15:0] a_out_ctrl [2:0];
    logic [15:0] a_in_data [0:0];
    logic [15:0] a_out_data [0:0];

    logic        b_flush, b_start, b_stall, b_in_ren, b_out_wen, b_busy, b_done;
    logic [15:0] b_in_ctrl [2:0];
    logic [15:0] b_out_ctrl [2:0];
    logic [15:0] b_in_data [0:0];
    logic [15:0] b_out_data [0:0];

    int n_tests = 0;
    int n_fail  = 0;

    // Sweep-position model for instance A
    bit          m_active;
    int          m_wait_left;
    int          m_idx;
    bit          m_wen;
    int          m_wy, m_wx;
    logic [15:0] m_data;
    int          cyc, a_writes, a_done_cyc;

    up_sample_nn_op_ctrl #(.EXTENT_X(EXA), .EXTENT_Y(EYA), .START_DELAY(DA), .DATA_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(a_flush), .start(a_start), .stall(a_stall),
        .in_ren(a_in_ren), .in_ctrl_vars(a_in_ctrl), .in_data(a_in_data),
        .out_wen(a_out_wen), .out_ctrl_vars(a_out_ctrl), .out_data(a_out_data),
        .busy(a_busy), .done(a_done)
    );

    up_sample_nn_op_ctrl #(.EXTENT_X(4), .EXTENT_Y(3), .START_DELAY(0), .DATA_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .start(b_start), .stall(b_stall),
        .in_ren(b_in_ren), .in_ctrl_vars(b_in_ctrl), .in_data(b_in_data),
        .out_wen(b_out_wen), .out_ctrl_vars(b_out_ctrl), .out_data(b_out_data),
        .busy(b_busy), .done(b_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          start;
        bit          stall;
        bit          ren;
        logic [15:0] y;
        logic [15:0] x;
        bit          chk_ctrl;
        bit          done;
        bit          busy;
    } vec_t;

    vec_t tbl [17];

    function automatic vec_t mk(bit st, bit sl, bit rn, logic [15:0] y, logic [15:0] x,
                                bit cc, bit dn, bit bz);
        vec_t v;
        v.start = st; v.stall = sl; v.ren = rn; v.y = y; v.x = x;
        v.chk_ctrl = cc; v.done = dn; v.busy = bz;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic m_clear();
        m_active = 1'b0; m_wait_left = 0; m_idx = 0;
        m_wen = 1'b0; m_wy = 0; m_wx = 0; m_data = 16'd0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_in_ren"},  32'(a_in_ren),  32'd0);
        chk({tag, "_in_c0"},   32'(a_in_ctrl[0]), 32'd0);
        chk({tag, "_in_y"},    32'(a_in_ctrl[1]), 32'd0);
        chk({tag, "_in_x"},    32'(a_in_ctrl[2]), 32'd0);
        chk({tag, "_out_wen"}, 32'(a_out_wen), 32'd0);
        chk({tag, "_out_c0"},  32'(a_out_ctrl[0]), 32'd0);
        chk({tag, "_out_y"},   32'(a_out_ctrl[1]), 32'd0);
        chk({tag, "_out_x"},   32'(a_out_ctrl[2]), 32'd0);
        chk({tag, "_out_data"}, 32'(a_out_data[0]), 32'd0);
        chk({tag, "_busy"},    32'(a_busy), 32'd0);
        chk({tag, "_done"},    32'(a_done), 32'd0);
    endtask

    // One cycle on instance A: drive, compare against the model, advance the model
    task automatic a_cycle(input bit st, input bit sl, input bit fl);
        bit e_run, e_ren, e_done;
        a_start = st; a_stall = sl; a_flush = fl; a_in_data[0] = 16'($urandom);
        #4;
        e_run  = m_active && (m_wait_left == 0) && (m_idx < NA);
        e_ren  = e_run && !sl;
        e_done = m_active && (m_wait_left == 0) && (m_idx == NA);
        chk("a_in_ren", 32'(a_in_ren), 32'(e_ren));
        chk("a_busy",   32'(a_busy),   32'(m_active));
        chk("a_done",   32'(a_done),   32'(e_done));
        if (e_run) begin
            chk("a_in_c0", 32'(a_in_ctrl[0]), 32'd0);
            chk("a_in_y",  32'(a_in_ctrl[1]), 32'(m_idx / EXA));
            chk("a_in_x",  32'(a_in_ctrl[2]), 32'(m_idx % EXA));
        end
        chk("a_out_wen", 32'(a_out_wen), 32'(m_wen));
        if (m_wen) begin
            chk("a_out_y", 32'(a_out_ctrl[1]), 32'(m_wy));
            chk("a_out_x", 32'(a_out_ctrl[2]), 32'(m_wx));
        end
        chk("a_out_data", 32'(a_out_data[0]), 32'(m_data));
        if (a_out_wen === 1'b1) a_writes++;
        if (a_done === 1'b1) a_done_cyc = cyc;
        if (fl) begin
            m_clear();
        end else begin
            m_wen = e_ren;
            m_wy  = m_idx / EXA;
            m_wx  = m_idx % EXA;
            if (e_ren) m_data = a_in_data[0];
            if (!m_active) begin
                if (st) begin
                    m_active = 1'b1; m_wait_left = DA; m_idx = 0;
                end
            end else if (m_wait_left > 0) begin
                m_wait_left--;
            end else if (m_idx < NA) begin
                if (!sl) m_idx++;
            end else begin
                m_active = 1'b0; m_idx = 0;
            end
        end
        cyc++;
        @(posedge clk); #1;
    endtask

    initial begin
        int s0, nst;
        bit sl;
        logic [15:0] b_last, b_py, b_px;
        bit b_prev_ren;

        a_flush = 0; a_start = 0; a_stall = 0; a_in_data[0] = 16'd0;
        b_flush = 0; b_start = 0; b_stall = 0; b_in_data[0] = 16'd0;
        m_clear(); cyc = 0; a_writes = 0; a_done_cyc = -1;

        tbl[0]  = mk(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        tbl[1]  = mk(1'b0, 1'b0, 1'b1, 16'd0, 16'd0, 1'b1, 1'b0, 1'b1);
        tbl[2]  = mk(1'b0, 1'b0, 1'b1, 16'd0, 16'd1, 1'b1, 1'b0, 1'b1);
        tbl[3]  = mk(1'b0, 1'b1, 1'b0, 16'd0, 16'd2, 1'b1, 1'b0, 1'b1);
        tbl[4]  = mk(1'b0, 1'b0, 1'b1, 16'd0, 16'd2, 1'b1, 1'b0, 1'b1);
        tbl[5]  = mk(1'b0, 1'b0, 1'b1, 16'd0, 16'd3, 1'b1, 1'b0, 1'b1);
        tbl[6]  = mk(1'b0, 1'b0, 1'b1, 16'd1, 16'd0, 1'b1, 1'b0, 1'b1);
        tbl[7]  = mk(1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 1'b0, 1'b1);
        tbl[8]  = mk(1'b0, 1'b0, 1'b1, 16'd1, 16'd2, 1'b1, 1'b0, 1'b1);
        tbl[9]  = mk(1'b0, 1'b0, 1'b1, 16'd1, 16'd3, 1'b1, 1'b0, 1'b1);
        tbl[10] = mk(1'b0, 1'b0, 1'b1, 16'd2, 16'd0, 1'b1, 1'b0, 1'b1);
        tbl[11] = mk(1'b0, 1'b0, 1'b1, 16'd2, 16'd1, 1'b1, 1'b0, 1'b1);
        tbl[12] = mk(1'b0, 1'b0, 1'b1, 16'd2, 16'd2, 1'b1, 1'b0, 1'b1);
        tbl[13] = mk(1'b0, 1'b0, 1'b1, 16'd2, 16'd3, 1'b1, 1'b0, 1'b1);
        tbl[14] = mk(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b1, 1'b1);
        tbl[15] = mk(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);
        tbl[16] = mk(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b0);

        @(posedge clk); #1;
        chk_a_zero("rst");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Small instance: zero start delay, one stall, row wraps, start ignored on done
        b_prev_ren = 1'b0; b_last = 16'd0; b_py = 16'd0; b_px = 16'd0;
        for (int i = 0; i < 17; i++) begin
            b_start = tbl[i].start; b_stall = tbl[i].stall; b_in_data[0] = 16'hB000 + 16'(i);
            #4;
            chk("b_in_ren",  32'(b_in_ren),  32'(tbl[i].ren));
            chk("b_done",    32'(b_done),    32'(tbl[i].done));
            chk("b_busy",    32'(b_busy),    32'(tbl[i].busy));
            chk("b_out_wen", 32'(b_out_wen), 32'(b_prev_ren));
            chk("b_out_data", 32'(b_out_data[0]), 32'(b_last));
            if (tbl[i].chk_ctrl) begin
                chk("b_in_y", 32'(b_in_ctrl[1]), 32'(tbl[i].y));
                chk("b_in_x", 32'(b_in_ctrl[2]), 32'(tbl[i].x));
            end
            if (b_prev_ren) begin
                chk("b_out_y", 32'(b_out_ctrl[1]), 32'(b_py));
                chk("b_out_x", 32'(b_out_ctrl[2]), 32'(b_px));
            end
            if (tbl[i].ren) b_last = b_in_data[0];
            b_prev_ren = tbl[i].ren; b_py = tbl[i].y; b_px = tbl[i].x;
            @(posedge clk); #1;
        end
        b_start = 1'b0; b_stall = 1'b0;

        // Sweep 1: no stalls, exact done timing and write count
        a_writes = 0; a_done_cyc = -1; s0 = cyc;
        a_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NA + 100 && m_active; i++) a_cycle(1'b0, 1'b0, 1'b0);
        chk("sweep1_ended", 32'(m_active), 32'd0);
        chk("sweep1_done_cyc", 32'(a_done_cyc - s0), 32'(DA + NA + 1));
        chk("sweep1_writes", 32'(a_writes), 32'(NA));

        // Sweep 2: three stall cycles at (y=2, x=5)
        a_writes = 0; a_done_cyc = -1; s0 = cyc; nst = 0;
        a_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NA + 100 && m_active; i++) begin
            sl = m_active && (m_wait_left == 0) && (m_idx == 2 * EXA + 5) && (nst < 3);
            if (sl) nst++;
            a_cycle(1'b0, sl, 1'b0);
        end
        chk("sweep2_ended", 32'(m_active), 32'd0);
        chk("sweep2_done_cyc", 32'(a_done_cyc - s0), 32'(DA + NA + 1 + 3));
        chk("sweep2_writes", 32'(a_writes), 32'(NA));

        // Sweep 3: random stalls and stray starts, async reset once y reaches 10
        a_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < NA && m_active && m_idx < 10 * EXA + 3; i++)
            a_cycle($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, 1'b0);
        chk("sweep3_reached_y10", 32'(m_idx >= 10 * EXA + 3), 32'd1);
        a_start = 1'b0; a_stall = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_a_zero("async_rst");
        m_clear();
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Flush while waiting, then a full sweep with random stalls and ignored starts
        a_cycle(1'b1, 1'b0, 1'b0);
        a_cycle(1'b0, 1'b0, 1'b0);
        a_cycle(1'b0, 1'b0, 1'b1);
        a_cycle(1'b0, 1'b0, 1'b0);
        a_writes = 0;
        a_cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2 * NA && m_active; i++)
            a_cycle($urandom_range(0, 31) == 0, $urandom_range(0, 7) == 0, 1'b0);
        chk("sweep4_ended", 32'(m_active), 32'd0);
        chk("sweep4_writes", 32'(a_writes), 32'(NA));
        a_cycle(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
